// File: rtl/norm_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// norm_ctrl_pkg
// Shared constants for the normalise/multiply/denormalise sequencer.
// The state register is a 7-bit one-hot vector; ST_*_IDX name each bit and
// ST_* are the corresponding one-hot codes used for decode and jump targets.
// -----------------------------------------------------------------------------
package norm_ctrl_pkg;

  localparam int ST_W = 7;

  localparam int ST_IDLE_IDX      = 0;
  localparam int ST_ARM_IDX       = 1;
  localparam int ST_LOAD_IDX      = 2;
  localparam int ST_NORM_IDX      = 3;
  localparam int ST_LOAD_RES_IDX  = 4;
  localparam int ST_SHIFT_RES_IDX = 5;
  localparam int ST_DONE_IDX      = 6;

  // Bit order follows the nominal run, so a left rotate advances one state.
  localparam logic [ST_W-1:0] ST_IDLE      = ST_W'(1) << ST_IDLE_IDX;
  localparam logic [ST_W-1:0] ST_ARM       = ST_W'(1) << ST_ARM_IDX;
  localparam logic [ST_W-1:0] ST_LOAD      = ST_W'(1) << ST_LOAD_IDX;
  localparam logic [ST_W-1:0] ST_NORM      = ST_W'(1) << ST_NORM_IDX;
  localparam logic [ST_W-1:0] ST_LOAD_RES  = ST_W'(1) << ST_LOAD_RES_IDX;
  localparam logic [ST_W-1:0] ST_SHIFT_RES = ST_W'(1) << ST_SHIFT_RES_IDX;
  localparam logic [ST_W-1:0] ST_DONE      = ST_W'(1) << ST_DONE_IDX;

endpackage

// File: rtl/norm_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// norm_seq_ctrl_if
// Control/strobe bundle between the sequencer and its surroundings.
//   master : drives start/abort/ack, per-channel end_shift and cntr_dual_co;
//            receives datapath strobes and status.
//   slave  : the sequencer itself (mirror directions).
// Outputs carried: load_shift, norm_en, en_shift, sel_sh (NCH wide each),
// sel_insh, cntr_norm_en, cntr_dual_en, cntr_dual_end, done, zero_flag,
// busy, state_err.
// -----------------------------------------------------------------------------
interface norm_seq_ctrl_if #(
  parameter int NCH = 2
);
  logic           start;
  logic           abort;
  logic           ack;
  logic [NCH-1:0] end_shift;
  logic           cntr_dual_co;

  logic [NCH-1:0] load_shift;
  logic [NCH-1:0] norm_en;
  logic [NCH-1:0] en_shift;
  logic [NCH-1:0] sel_sh;
  logic           sel_insh;
  logic           cntr_norm_en;
  logic           cntr_dual_en;
  logic           cntr_dual_end;
  logic           done;
  logic           zero_flag;
  logic           busy;
  logic           state_err;

  modport master (
    output start, abort, ack, end_shift, cntr_dual_co,
    input  load_shift, norm_en, en_shift, sel_sh, sel_insh, cntr_norm_en,
           cntr_dual_en, cntr_dual_end, done, zero_flag, busy, state_err
  );

  modport slave (
    input  start, abort, ack, end_shift, cntr_dual_co,
    output load_shift, norm_en, en_shift, sel_sh, sel_insh, cntr_norm_en,
           cntr_dual_en, cntr_dual_end, done, zero_flag, busy, state_err
  );
endinterface

// File: rtl/norm_seq_ctrl_ring.sv
// -----------------------------------------------------------------------------
// onehot_ring
// One-hot state register. Priority: rst > i_load > i_rotate > hold.
//   clk, rst    : rising-edge clock, synchronous active-high reset to RST_VAL
//   i_rotate    : advance one position (bit i -> bit i+1, MSB wraps to LSB)
//   i_load      : jump to i_load_val
//   i_load_val  : jump target
//   o_state     : current state vector
// -----------------------------------------------------------------------------
module onehot_ring #(
  parameter int               WIDTH   = 7,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_rotate,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_state
);

  logic [WIDTH-1:0] r_state;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values, independent of block evaluation order.
    if (rst) begin
      r_state <= RST_VAL;
    end else if (i_load) begin
      r_state <= i_load_val;
    end else if (i_rotate) begin
      r_state <= {r_state[WIDTH-2:0], r_state[WIDTH-1]};
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/norm_seq_ctrl.sv
// -----------------------------------------------------------------------------
// norm_seq_ctrl
// One-hot sequencer for the normalise/multiply/denormalise datapath:
// IDLE -> ARM -> LOAD -> NORM -> LOAD_RES -> SHIFT_RES -> DONE -> IDLE.
// NORM is bounded to NORM_MAX cycles; a timeout means a zero operand and goes
// straight to DONE with zero_flag set. abort returns to IDLE from anywhere.
// A non-one-hot state blanks all outputs, pulses state_err and recovers to IDLE.
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : norm_seq_ctrl_if.slave (start/abort/ack/end_shift/cntr_dual_co in,
//          datapath strobes and status out)
// -----------------------------------------------------------------------------
module norm_seq_ctrl
  import norm_ctrl_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int NORM_MAX  = 8,
  parameter int NORM_CW   = $clog2(NORM_MAX + 1),
  parameter int DONE_HOLD = 0
) (
  input logic            clk,
  input logic            rst,
  norm_seq_ctrl_if.slave bus
);

  logic [ST_W-1:0]    w_state;
  logic [ST_W-1:0]    w_load_val;
  logic               w_rotate;
  logic               w_load;
  logic               w_timeout;
  logic               w_enter_load;
  logic               w_legal;
  logic               w_st_idle, w_st_arm, w_st_load, w_st_norm;
  logic               w_st_load_res, w_st_shift_res, w_st_done;
  logic [NORM_CW-1:0] r_norm_cnt;
  logic               r_zero_flag;

  onehot_ring #(
    .WIDTH   (ST_W),
    .RST_VAL (ST_IDLE)
  ) u_ring (
    .clk        (clk),
    .rst        (rst),
    .i_rotate   (w_rotate),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_state    (w_state)
  );

  // Full-vector compares: an illegal vector matches no state, so every
  // decode below is already blanked when the state is corrupt.
  assign w_legal        = $onehot(w_state);
  assign w_st_idle      = (w_state == ST_IDLE);
  assign w_st_arm       = (w_state == ST_ARM);
  assign w_st_load      = (w_state == ST_LOAD);
  assign w_st_norm      = (w_state == ST_NORM);
  assign w_st_load_res  = (w_state == ST_LOAD_RES);
  assign w_st_shift_res = (w_state == ST_SHIFT_RES);
  assign w_st_done      = (w_state == ST_DONE);

  always_comb begin
    // NOTE: every combinational output is defaulted first, so no branch can
    // leave one unassigned and no latch is inferred.
    w_rotate     = 1'b0;
    w_load       = 1'b0;
    w_load_val   = ST_IDLE;
    w_timeout    = 1'b0;
    w_enter_load = 1'b0;
    if (!w_legal || bus.abort) begin
      w_load = 1'b1;                       // recovery and abort both jump to IDLE
    end else if (w_st_idle) begin
      w_rotate = bus.start;
    end else if (w_st_arm) begin
      w_rotate     = !bus.start;           // run begins on start release
      w_enter_load = !bus.start;
    end else if (w_st_load || w_st_load_res) begin
      w_rotate = 1'b1;
    end else if (w_st_norm) begin
      if (!(|bus.end_shift)) begin
        w_rotate = 1'b1;                   // normalised wins over same-cycle timeout
      end else if (r_norm_cnt == NORM_CW'(NORM_MAX - 1)) begin
        w_load     = 1'b1;
        w_load_val = ST_DONE;
        w_timeout  = 1'b1;
      end
    end else if (w_st_shift_res) begin
      w_rotate = bus.cntr_dual_co;
    end else if (w_st_done) begin
      w_load = (DONE_HOLD == 0) || bus.ack;
    end
  end

  // NORM cycle counter: zero outside NORM, saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || !w_st_norm) begin
      r_norm_cnt <= '0;
    end else if (r_norm_cnt != NORM_CW'(NORM_MAX)) begin
      r_norm_cnt <= r_norm_cnt + 1'b1;
    end
  end

  // zero_flag reports the last run; it survives abort and DONE for readout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_zero_flag <= 1'b0;
    end else if (w_timeout) begin
      r_zero_flag <= 1'b1;
    end else if (w_enter_load) begin
      r_zero_flag <= 1'b0;
    end
  end

  assign bus.load_shift    = {NCH{w_st_load | w_st_load_res}};
  assign bus.norm_en       = w_st_norm ? bus.end_shift : '0;
  assign bus.en_shift      = {NCH{w_st_shift_res}};
  assign bus.sel_sh        = {NCH{w_st_load_res}};
  assign bus.sel_insh      = w_st_shift_res;
  assign bus.cntr_norm_en  = w_st_norm;
  assign bus.cntr_dual_en  = w_st_norm;
  assign bus.cntr_dual_end = w_st_shift_res;
  assign bus.done          = w_st_done;
  assign bus.zero_flag     = w_legal & r_zero_flag;
  assign bus.busy          = w_legal & ~w_st_idle;
  assign bus.state_err     = ~w_legal;

endmodule
